instr_sequencer: RTL

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/seq_pkg.sv | 15 +
 rtl/seq_watchdog.sv | 29 ++
 rtl/instr_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types for the instruction sequencer: state encoding and default counter width.
// The optional watchdog is enabled by defining SEQ_TIMEOUT_EN.
package seq_pkg;

  localparam int SEQ_COUNT_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RETIRE = 3'd3,
    ST_HALTED = 3'd4
  } seq_state_e;

endpackage

// File: rtl/seq_watchdog.sv
// WAIT-cycle watchdog: counts cycles while run is high, flags expiry on the last allowed cycle.
// Only instantiated when SEQ_TIMEOUT_EN is defined.
module seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // r_cnt holds the number of completed run cycles; the cycle that sees LAST is the final one.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_cnt <= '0;
    end else if (run && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired = run && (r_cnt == LAST);

endmodule

// File: rtl/instr_sequencer.sv
// Issue/wait/retire sequencer for a datapath unit with single-step, halt and retired-op counting.
// Define SEQ_TIMEOUT_EN to add a WAIT watchdog that halts the sequencer with a sticky timeout_err.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int COUNT_W        = SEQ_COUNT_W_DEFAULT,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               step_mode,
  input  logic               step,
  input  logic               halt,
  input  logic               done,
  output logic               start,
  output logic               busy,
  output logic [2:0]         state_o,
  output logic [COUNT_W-1:0] count,
  output logic               count_wrap,
  output logic               timeout_err
);

  if (COUNT_W < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("instr_sequencer: COUNT_W and TIMEOUT_CYCLES must be at least 1");
  end

  seq_state_e         r_state;
  logic [COUNT_W-1:0] r_count;
  logic               r_start;
  logic               r_busy;
  logic               r_wrap;
  logic               r_halt_pend;

`ifdef SEQ_TIMEOUT_EN
  logic w_expired;
  logic r_timeout;

  seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (r_state != ST_WAIT),
    .run     ((r_state == ST_WAIT) && !done),
    .expired (w_expired)
  );

  assign timeout_err = r_timeout;
`else
  assign timeout_err = 1'b0;
`endif

  // start and busy are registered alongside the state so they line up with state_o.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_start     <= 1'b0;
      r_busy      <= 1'b0;
      r_wrap      <= 1'b0;
      r_halt_pend <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      r_timeout   <= 1'b0;
`endif
    end else begin
      r_start <= 1'b0;
      r_wrap  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (halt) begin
            r_state <= ST_HALTED;
            r_busy  <= 1'b0;
          end else if (enable && (!step_mode || step)) begin
            r_state <= ST_ISSUE;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT;
          if (halt) r_halt_pend <= 1'b1;
        end
        ST_WAIT: begin
          if (halt) r_halt_pend <= 1'b1;
          if (done) begin
            r_state <= ST_RETIRE;
            r_count <= r_count + 1'b1;
            r_wrap  <= &r_count;
          end
`ifdef SEQ_TIMEOUT_EN
          else if (w_expired) begin
            r_state   <= ST_HALTED;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
          end
`endif
        end
        ST_RETIRE: begin
          // A halt seen at any point during the operation wins over re-issue.
          if (r_halt_pend || halt) begin
            r_state <= ST_HALTED;
            r_busy  <= 1'b0;
          end else if (step_mode) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (enable) begin
            r_state <= ST_ISSUE;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_HALTED: begin
          r_busy <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign start      = r_start;
  assign busy       = r_busy;
  assign state_o    = r_state;
  assign count      = r_count;
  assign count_wrap = r_wrap;

endmodule
